dvp_pixel_transmitter: RTL and testbench



---
 rtl/dvp_tx_pkg.sv | 40 ++++
 rtl/dvp_tx_timing_gen.sv | 125 ++++++++++++
 rtl/dvp_pixel_transmitter.sv | 106 ++++++++++
 tb/tb_dvp_pixel_transmitter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_tx_pkg.sv
// rtl/dvp_tx_pkg.sv - shared state encoding, counter widths and colour-bar constants for the DVP transmitter
package dvp_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBP    = 3'd2,
      ACTIVE = 3'd3,
      VFP    = 3'd4
   } tx_state_t;

   // Slot counter holds up to 2*65535 + blanking slots; line counter holds a 16-bit depth.
   localparam int SLOT_W = 18;
   localparam int LINE_W = 16;

   localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_BLUE    = 16'h001F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = RGB_WHITE;
         3'd1:    c = RGB_YELLOW;
         3'd2:    c = RGB_CYAN;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_MAGENTA;
         3'd5:    c = RGB_RED;
         3'd6:    c = RGB_BLUE;
         default: c = RGB_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dvp_tx_timing_gen.sv
// rtl/dvp_tx_timing_gen.sv - PCLK phase, slot/line counters and frame FSM for the DVP transmitter
module dvp_tx_timing_gen
   import dvp_tx_pkg::*;
#(
   parameter int   VSYNC_LINES  = 4,
   parameter int   VBP_LINES    = 8,
   parameter int   VFP_LINES    = 4,
   parameter int   HBLANK_SLOTS = 64,
   parameter logic VSYNC_POL    = 1'b1
)(
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_enable,
   input  logic [15:0] i_width,
   input  logic [15:0] i_depth,
   output logic        o_pclk,
   output logic        o_href,
   output logic        o_vsync,
   output logic        o_odd,
   output logic        o_req,
   output logic        o_done,
   output logic        o_busy,
   output logic [15:0] o_width
);

   tx_state_t          r_state, w_state_nxt;
   logic               r_phase;
   logic [SLOT_W-1:0]  r_slot, w_slot_nxt;
   logic [LINE_W-1:0]  r_line, w_line_nxt;
   logic [15:0]        r_w, r_d;
   logic [SLOT_W-1:0]  w_act_slots, w_line_len;
   logic               w_start_ok, w_last_slot, w_load, w_done, w_req_nxt;

   assign w_start_ok  = i_enable && (i_width != 16'd0) && (i_depth != 16'd0);
   assign w_act_slots = SLOT_W'({r_w, 1'b0});
   assign w_line_len  = w_act_slots + SLOT_W'(HBLANK_SLOTS);
   assign w_last_slot = (r_slot == w_line_len - SLOT_W'(1));

   // Next pixel request: odd slot preceding an even active slot, or last slot of the line before an active line.
   assign w_req_nxt = ((r_state == ACTIVE) && r_slot[0] && (r_slot < w_act_slots - SLOT_W'(1)))
                   || (w_last_slot && (((r_state == VBP) && (r_line == LINE_W'(VBP_LINES - 1)))
                                    || ((r_state == ACTIVE) && (r_line != r_d - LINE_W'(1)))));

   assign o_pclk  = r_phase;
   assign o_busy  = (r_state != IDLE);
   assign o_width = r_w;

   // Where the counters and FSM land at the next slot boundary.
   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot + SLOT_W'(1);
      w_line_nxt  = r_line;
      w_load      = 1'b0;
      w_done      = 1'b0;
      if (r_state == IDLE) begin
         w_slot_nxt = '0;
         w_line_nxt = '0;
         if (w_start_ok) begin
            w_state_nxt = VSYNC;
            w_load      = 1'b1;
         end
      end else if (w_last_slot) begin
         w_slot_nxt = '0;
         w_line_nxt = r_line + LINE_W'(1);
         case (r_state)
            VSYNC: if (r_line == LINE_W'(VSYNC_LINES - 1)) begin
               w_state_nxt = VBP;
               w_line_nxt  = '0;
            end
            VBP: if (r_line == LINE_W'(VBP_LINES - 1)) begin
               w_state_nxt = ACTIVE;
               w_line_nxt  = '0;
            end
            ACTIVE: if (r_line == r_d - LINE_W'(1)) begin
               w_state_nxt = VFP;
               w_line_nxt  = '0;
            end
            VFP: if (r_line == LINE_W'(VFP_LINES - 1)) begin
               w_done      = 1'b1;
               w_line_nxt  = '0;
               w_state_nxt = w_start_ok ? VSYNC : IDLE;
               w_load      = w_start_ok;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Frame FSM with registered DVP outputs; line-level outputs only move at phase-0 starts.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_state <= IDLE;
         r_phase <= 1'b0;
         r_slot  <= '0;
         r_line  <= '0;
         r_w     <= '0;
         r_d     <= '0;
         o_href  <= 1'b0;
         o_vsync <= ~VSYNC_POL;
         o_odd   <= 1'b0;
         o_req   <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         o_done  <= 1'b0;
         o_req   <= 1'b0;
         r_phase <= (r_state == IDLE) ? 1'b0 : ~r_phase;
         if (w_load) begin
            r_w <= i_width;
            r_d <= i_depth;
         end
         if ((r_state == IDLE) || r_phase) begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_line  <= w_line_nxt;
            o_done  <= w_done;
            o_href  <= (w_state_nxt == ACTIVE) && (w_slot_nxt < w_act_slots);
            o_vsync <= (w_state_nxt == VSYNC) ? VSYNC_POL : ~VSYNC_POL;
            o_odd   <= w_slot_nxt[0];
         end else begin
            o_req   <= w_req_nxt;
         end
      end
   end

endmodule

// File: rtl/dvp_pixel_transmitter.sv
// rtl/dvp_pixel_transmitter.sv - RGB565 stream to DVP transmitter; DVP_TX_TEST_PATTERN_EN adds the colour-bar source
module dvp_pixel_transmitter
   import dvp_tx_pkg::*;
#(
   parameter int          VSYNC_LINES    = 4,
   parameter int          VBP_LINES      = 8,
   parameter int          VFP_LINES      = 4,
   parameter int          HBLANK_SLOTS   = 64,
   parameter logic        VSYNC_POL      = 1'b1,
   parameter logic [15:0] UNDERFLOW_FILL = 16'h0000
)(
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        enable_i,
   input  logic [15:0] resolution_width_i,
   input  logic [15:0] resolution_depth_i,
   input  logic [15:0] pixel_data_i,
   input  logic        pixel_valid_i,
`ifdef DVP_TX_TEST_PATTERN_EN
   input  logic        pattern_sel_i,
`endif
   output logic        pixel_ready_o,
   output logic        cam_pclk_o,
   output logic [7:0]  cam_half_pixel_o,
   output logic        cam_href_o,
   output logic        cam_vsync_o,
   output logic        frame_done_o,
   output logic        underflow_o,
   output logic        busy_o
);

   logic        w_req, w_odd, w_pattern;
   logic [15:0] w_width, w_bar_pix;
   logic [15:0] r_pix;
   logic        r_underflow;

   dvp_tx_timing_gen #(
      .VSYNC_LINES  (VSYNC_LINES),
      .VBP_LINES    (VBP_LINES),
      .VFP_LINES    (VFP_LINES),
      .HBLANK_SLOTS (HBLANK_SLOTS),
      .VSYNC_POL    (VSYNC_POL)
   ) u_timing (
      .i_clk    (clk_i),
      .i_resetn (resetn_i),
      .i_enable (enable_i),
      .i_width  (resolution_width_i),
      .i_depth  (resolution_depth_i),
      .o_pclk   (cam_pclk_o),
      .o_href   (cam_href_o),
      .o_vsync  (cam_vsync_o),
      .o_odd    (w_odd),
      .o_req    (w_req),
      .o_done   (frame_done_o),
      .o_busy   (busy_o),
      .o_width  (w_width)
   );

`ifdef DVP_TX_TEST_PATTERN_EN
   logic [15:0] r_x;
   logic [18:0] w_x8;
   logic [2:0]  w_bar;

   assign w_pattern = pattern_sel_i;
   assign w_x8      = {r_x, 3'b000};
   assign w_bar     = 3'(w_x8 / {3'b000, w_width});
   assign w_bar_pix = bar_color(w_bar);

   // Pixel column of the next request; exactly W requests per line bring it back to 0.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         r_x <= '0;
      end else if (w_req) begin
         r_x <= (r_x == w_width - 16'd1) ? 16'd0 : r_x + 16'd1;
      end
   end
`else
   logic w_unused_width;

   assign w_pattern      = 1'b0;
   assign w_bar_pix      = RGB_BLACK;
   assign w_unused_width = ^w_width;
`endif

   assign pixel_ready_o    = w_req & ~w_pattern;
   assign underflow_o      = r_underflow;
   assign cam_half_pixel_o = cam_href_o ? (w_odd ? r_pix[7:0] : r_pix[15:8]) : 8'h00;

   // Take the next pixel at the end of the request cycle, which is also the start of its high-byte slot.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         r_pix       <= '0;
         r_underflow <= 1'b0;
      end else if (w_req) begin
         if (w_pattern) begin
            r_pix <= w_bar_pix;
         end else if (pixel_valid_i) begin
            r_pix <= pixel_data_i;
         end else begin
            r_pix       <= UNDERFLOW_FILL;
            r_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dvp_pixel_transmitter.sv
// tb/tb_dvp_pixel_transmitter.sv - directed self-checking bench for dvp_pixel_transmitter
module tb_dvp_pixel_transmitter;

   logic        clk_i = 1'b0;
   logic        resetn_i, enable_i, pixel_valid_i;
   logic [15:0] resolution_width_i, resolution_depth_i, pixel_data_i;
   logic        pixel_ready_o, cam_pclk_o, cam_href_o, cam_vsync_o;
   logic        frame_done_o, underflow_o, busy_o;
   logic [7:0]  cam_half_pixel_o;
`ifdef DVP_TX_TEST_PATTERN_EN
   logic        pattern_sel_i;
`endif

   always #5 clk_i = ~clk_i;

   dvp_pixel_transmitter dut (
      .clk_i              (clk_i),
      .resetn_i           (resetn_i),
      .enable_i           (enable_i),
      .resolution_width_i (resolution_width_i),
      .resolution_depth_i (resolution_depth_i),
      .pixel_data_i       (pixel_data_i),
      .pixel_valid_i      (pixel_valid_i),
`ifdef DVP_TX_TEST_PATTERN_EN
      .pattern_sel_i      (pattern_sel_i),
`endif
      .pixel_ready_o      (pixel_ready_o),
      .cam_pclk_o         (cam_pclk_o),
      .cam_half_pixel_o   (cam_half_pixel_o),
      .cam_href_o         (cam_href_o),
      .cam_vsync_o        (cam_vsync_o),
      .frame_done_o       (frame_done_o),
      .underflow_o        (underflow_o),
      .busy_o             (busy_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_slots = 0, n_vs = 0, n_href = 0, n_done = 0, nreq = 0, drop_k = -1;
   int done_slot = -1, vs_at_done = -1, href_at_done = -1, req_at_done = -1, first_novs = -1;
   int cyc, h0, vs0, bad;
   int       href_slot[$];
   logic [7:0] bytes[$];

   function automatic logic [15:0] pix(input int k);
      logic [31:0] t;
      t = 32'h1234 + 32'(k) * 32'h4444;
      return t[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clk_i cycle: observe at the falling edge, then update the pixel source after the rising edge.
   task automatic tick();
      logic rdy;
      @(negedge clk_i);
      if (frame_done_o) begin
         n_done++;
         done_slot    = n_slots;
         vs_at_done   = n_vs;
         href_at_done = n_href;
         req_at_done  = nreq;
      end
      if (busy_o && !cam_pclk_o) begin
         if (cam_vsync_o) n_vs++;
         else if (first_novs < 0) first_novs = n_slots;
         if (cam_href_o) begin
            n_href++;
            href_slot.push_back(n_slots);
            bytes.push_back(cam_half_pixel_o);
         end
         n_slots++;
      end
      rdy = pixel_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) nreq++;
      pixel_data_i  = pix(nreq);
      pixel_valid_i = (nreq != drop_k);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn_i = 1'b0; enable_i = 1'b0;
      resolution_width_i = 16'd4; resolution_depth_i = 16'd2;
      pixel_data_i = pix(0); pixel_valid_i = 1'b1;
`ifdef DVP_TX_TEST_PATTERN_EN
      pattern_sel_i = 1'b0;
`endif
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_pclk", cam_pclk_o, 0);
      chk("rst_byte", cam_half_pixel_o, 0);
      chk("rst_href", cam_href_o, 0);
      chk("rst_vsync", cam_vsync_o, 0);
      chk("rst_ready", pixel_ready_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_underflow", underflow_o, 0);
      chk("rst_busy", busy_o, 0);
      resetn_i = 1'b1; enable_i = 1'b1;

      // Frame 1: W=4 D=2, source always valid.
      cyc = 0;
      while (n_done < 1 && cyc < 6000) begin tick(); cyc++; end
      chk("f1_done_seen", n_done, 1);
      chk("f1_done_slot", done_slot, 1296);
      chk("f1_vsync_slots", vs_at_done, 288);
      chk("f1_first_blank", first_novs, 288);
      chk("f1_href_slots", href_at_done, 16);
      chk("f1_first_href", href_slot[0], 864);
      chk("f1_l0_last_href", href_slot[7], 871);
      chk("f1_l1_first_href", href_slot[8], 936);
      chk("f1_b0", bytes[0], 8'h12);
      chk("f1_b1", bytes[1], 8'h34);
      chk("f1_b2", bytes[2], 8'h56);
      chk("f1_b3", bytes[3], 8'h78);
      chk("f1_b8", bytes[8], 8'h23);
      chk("f1_b9", bytes[9], 8'h44);
      chk("f1_requests", req_at_done, 8);
      chk("f1_underflow", underflow_o, 0);
      chk("f2_busy", busy_o, 1);

      // Frame 2: third pixel not valid.
      drop_k = 10;
      cyc = 0;
      while (n_done < 2 && cyc < 6000) begin tick(); cyc++; end
      chk("f2_done_seen", n_done, 2);
      chk("f2_b16", bytes[16], 8'h34);
      chk("f2_b17", bytes[17], 8'h54);
      chk("f2_b18", bytes[18], 8'h78);
      chk("f2_b19", bytes[19], 8'h98);
      chk("f2_fill_hi", bytes[20], 8'h00);
      chk("f2_fill_lo", bytes[21], 8'h00);
      chk("f2_b22", bytes[22], 8'h01);
      chk("f2_b23", bytes[23], 8'h20);
      chk("f3_underflow_sticky", underflow_o, 1);
      chk("f3_busy", busy_o, 1);

      // Frame 3: enable dropped mid second active line.
      h0 = n_href;
      cyc = 0;
      while (n_href < h0 + 12 && cyc < 6000) begin tick(); cyc++; end
      chk("f3_mid_line1", n_href, h0 + 12);
      enable_i = 1'b0;
      cyc = 0;
      while (n_done < 3 && cyc < 6000) begin tick(); cyc++; end
      chk("f3_done_seen", n_done, 3);
      chk("f3_href_total", href_at_done, 48);
      chk("f3_idle_busy", busy_o, 0);
      vs0 = n_vs;
      repeat (1000) tick();
      chk("f3_no_restart", n_vs, vs0);
      chk("f3_done_once", n_done, 3);
      chk("f3_still_idle", busy_o, 0);

      // Reset during ACTIVE, then restart.
      enable_i = 1'b1;
      cyc = 0;
      while (!cam_href_o && cyc < 6000) begin tick(); cyc++; end
      chk("f4_reached_active", cam_href_o, 1);
      resetn_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("mid_rst_pclk", cam_pclk_o, 0);
      chk("mid_rst_byte", cam_half_pixel_o, 0);
      chk("mid_rst_href", cam_href_o, 0);
      chk("mid_rst_vsync", cam_vsync_o, 0);
      chk("mid_rst_ready", pixel_ready_o, 0);
      chk("mid_rst_done", frame_done_o, 0);
      chk("mid_rst_underflow", underflow_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      resetn_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("restart_vsync", cam_vsync_o, 1);
      chk("restart_busy", busy_o, 1);
      chk("restart_pclk_lo", cam_pclk_o, 0);
      @(negedge clk_i);
      chk("restart_pclk_hi", cam_pclk_o, 1);

      // Zero width keeps the block idle.
      #1;
      resetn_i = 1'b0;
      @(posedge clk_i);
      #1;
      resolution_width_i = 16'd0;
      resetn_i = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clk_i);
         if (busy_o || cam_pclk_o) bad++;
      end
      chk("zero_width_idle", bad, 0);

`ifdef DVP_TX_TEST_PATTERN_EN
      begin
         logic [7:0] exp_bars [16];
         exp_bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                      8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
         enable_i = 1'b0;
         resetn_i = 1'b0;
         @(posedge clk_i);
         #1;
         resolution_width_i = 16'd8;
         resolution_depth_i = 16'd1;
         pattern_sel_i = 1'b1;
         resetn_i = 1'b1;
         enable_i = 1'b1;
         bytes.delete();
         h0 = n_done;
         vs0 = nreq;
         cyc = 0;
         while (n_done < h0 + 1 && cyc < 6000) begin
            tick();
            cyc++;
            if (n_done == h0 + 1) enable_i = 1'b0;
         end
         chk("pat_done_seen", n_done, h0 + 1);
         for (int i = 0; i < 16; i++) chk($sformatf("pat_b%0d", i), bytes[i], exp_bars[i]);
         chk("pat_no_ready", nreq, vs0);
         chk("pat_no_underflow", underflow_o, 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
